// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD constants for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOP     = 2'd2,
        ST_OVERFLOW = 2'd3
    } state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one chainable BCD digit wrapping at LIMIT, with clear and saturate
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] LIMIT = DIGIT_MAX
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sat_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);

    logic [BCD_W-1:0] digit_q, digit_d;

    // Saturation beats the increment so the max-time tick cannot wrap.
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (sat_i) begin
            digit_d = LIMIT;
        end else if (en_i) begin
            digit_d = (digit_q == LIMIT) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = en_i && (digit_q == LIMIT);

endmodule

// File: rtl/stopwatch_lap_controller.sv
// rtl/stopwatch_lap_controller.sv - BCD stopwatch with lap capture buffer and lap recall display mux
module stopwatch_lap_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 20,
    parameter int MIN_DIGITS = 2,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             toggle_i,
    input  logic                             lap_i,
    input  logic                             recall_i,
    output logic [3:0]                       dsec_o,
    output logic [3:0]                       sec0_o,
    output logic [3:0]                       sec1_o,
    output logic [4*MIN_DIGITS-1:0]          min_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_sel_o,
    output logic                             lap_full_o,
    output logic                             overflow_o
);

    localparam int ND   = 3 + MIN_DIGITS;
    localparam int DW   = BCD_W * ND;
    localparam int DIVW = $clog2(TICK_DIV);
    localparam int CW   = $clog2(LAP_DEPTH + 1);

    state_t            state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     sel_q, sel_d;
    logic [DW-1:0]     lap_q [LAP_DEPTH];
    logic [DW-1:0]     live, disp;
    logic [ND-1:0]     en, carry;
    logic              running, stopped, tick, max_carry, clr, lap_we, full;

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; the max-time carry outranks a same-cycle toggle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (toggle_i) state_d = ST_RUN;
            ST_RUN: begin
                if (max_carry)     state_d = ST_OVERFLOW;
                else if (toggle_i) state_d = ST_STOP;
            end
            ST_STOP:     if (toggle_i) state_d = ST_RUN;
            ST_OVERFLOW: if (toggle_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        running    = (state_q == ST_RUN);
        stopped    = (state_q == ST_STOP) || (state_q == ST_OVERFLOW);
        overflow_o = (state_q == ST_OVERFLOW);
    end

    always_comb begin
        div_d = '0;
        if (running) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end else if (state_q == ST_STOP) begin
            div_d = div_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick      = running && (div_q == DIVW'(TICK_DIV - 1));
    assign clr       = (state_q == ST_OVERFLOW) && toggle_i;
    assign en        = {carry[ND-2:0], tick};
    assign max_carry = carry[ND-1];

    for (genvar g = 0; g < ND; g++) begin : g_digit
        bcd_digit_counter #(
            .LIMIT((g == 2) ? SEC_TENS_MAX : DIGIT_MAX)
        ) u_digit (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr),
            .en_i    (en[g]),
            .sat_i   (max_carry),
            .digit_o (live[g*BCD_W +: BCD_W]),
            .carry_o (carry[g])
        );
    end

    assign full   = (count_q == CW'(LAP_DEPTH));
    assign lap_we = running && lap_i && !full;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (lap_we) begin
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (stopped && toggle_i) begin
            sel_d = '0;
        end else if (stopped && recall_i && (count_q != '0)) begin
            sel_d = (sel_q == count_q) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            sel_q   <= '0;
        end else begin
            count_q <= count_d;
            sel_q   <= sel_d;
        end
    end

    // Entries capture the registered digits, i.e. the value before a same-cycle tick.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            for (int k = 0; k < LAP_DEPTH; k++) lap_q[k] <= '0;
        end else if (lap_we) begin
            for (int k = 0; k < LAP_DEPTH; k++) begin
                if (count_q == CW'(k)) lap_q[k] <= live;
            end
        end
    end

    always_comb begin
        disp = live;
        for (int k = 0; k < LAP_DEPTH; k++) begin
            if (sel_q == CW'(k + 1)) disp = lap_q[k];
        end
    end

    assign dsec_o      = disp[3:0];
    assign sec0_o      = disp[7:4];
    assign sec1_o      = disp[11:8];
    assign min_o       = disp[DW-1:12];
    assign lap_count_o = count_q;
    assign lap_sel_o   = sel_q;
    assign lap_full_o  = full;

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// tb/tb_stopwatch_lap_controller.sv - directed self-checking bench for stopwatch_lap_controller
module tb_stopwatch_lap_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: two minute digits, two lap entries
    logic       m_toggle = 1'b0, m_lap = 1'b0, m_recall = 1'b0;
    logic [3:0] m_dsec, m_sec0, m_sec1;
    logic [7:0] m_min;
    logic [1:0] m_count, m_sel;
    logic       m_full, m_ovf;

    // overflow instance: one minute digit, four lap entries
    logic       o_toggle = 1'b0, o_lap = 1'b0, o_recall = 1'b0;
    logic [3:0] o_dsec, o_sec0, o_sec1;
    logic [3:0] o_min;
    logic [2:0] o_count, o_sel;
    logic       o_full, o_ovf;

    stopwatch_lap_controller #(.TICK_DIV(2), .MIN_DIGITS(2), .LAP_DEPTH(2)) u_main (
        .clk_i(clk), .rst_i(rst), .toggle_i(m_toggle), .lap_i(m_lap), .recall_i(m_recall),
        .dsec_o(m_dsec), .sec0_o(m_sec0), .sec1_o(m_sec1), .min_o(m_min),
        .lap_count_o(m_count), .lap_sel_o(m_sel), .lap_full_o(m_full), .overflow_o(m_ovf)
    );

    stopwatch_lap_controller #(.TICK_DIV(2), .MIN_DIGITS(1), .LAP_DEPTH(4)) u_ovf (
        .clk_i(clk), .rst_i(rst), .toggle_i(o_toggle), .lap_i(o_lap), .recall_i(o_recall),
        .dsec_o(o_dsec), .sec0_o(o_sec0), .sec1_o(o_sec1), .min_o(o_min),
        .lap_count_o(o_count), .lap_sel_o(o_sel), .lap_full_o(o_full), .overflow_o(o_ovf)
    );

    logic [31:0] m_disp, o_disp;
    assign m_disp = {12'h0, m_min, m_sec1, m_sec0, m_dsec};
    assign o_disp = {16'h0, o_min, o_sec1, o_sec0, o_dsec};

    int vectors = 0;
    int miscompares = 0;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk_n(2);
        rst = 1'b0;
        check("rst_m_disp",  m_disp, 32'h0);
        check("rst_m_count", {30'h0, m_count}, 32'h0);
        check("rst_m_sel",   {30'h0, m_sel}, 32'h0);
        check("rst_m_flags", {30'h0, m_full, m_ovf}, 32'h0);
        check("rst_o_disp",  o_disp, 32'h0);

        // overflow with a single minute digit
        o_toggle = 1'b1; clk_n(1); o_toggle = 1'b0;
        o_lap = 1'b1; clk_n(1); o_lap = 1'b0;
        check("ovf_lap0", {29'h0, o_count}, 32'h1);
        clk_n(11997);
        check("ovf_at_max", o_disp, 32'h9599);
        check("ovf_not_yet", {31'h0, o_ovf}, 32'h0);
        clk_n(1);
        check("ovf_max_hold", o_disp, 32'h9599);
        clk_n(1);
        check("ovf_flag", {31'h0, o_ovf}, 32'h1);
        check("ovf_sat", o_disp, 32'h9599);
        clk_n(5);
        check("ovf_hold", o_disp, 32'h9599);
        check("ovf_flag_hold", {31'h0, o_ovf}, 32'h1);
        o_recall = 1'b1; clk_n(1); o_recall = 1'b0;
        check("ovf_recall_sel", {29'h0, o_sel}, 32'h1);
        check("ovf_recall_disp", o_disp, 32'h0);
        o_toggle = 1'b1; clk_n(1); o_toggle = 1'b0;
        check("ovf_clear_disp", o_disp, 32'h0);
        check("ovf_clear_count", {29'h0, o_count}, 32'h0);
        check("ovf_clear_sel", {29'h0, o_sel}, 32'h0);
        check("ovf_clear_flag", {31'h0, o_ovf}, 32'h0);
        o_lap = 1'b1; clk_n(1); o_lap = 1'b0;
        check("idle_lap_ignored", {29'h0, o_count}, 32'h0);

        // run counting, stop/hold, resume with divider phase kept
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        check("run_start", m_disp, 32'h0);
        clk_n(210);
        check("run_10_5", m_disp, 32'h00105);
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        check("stop_value", m_disp, 32'h00105);
        clk_n(50);
        check("stop_hold", m_disp, 32'h00105);
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        check("resume_edge", m_disp, 32'h00105);
        clk_n(1);
        check("resume_phase", m_disp, 32'h00106);

        // carry chain
        clk_n(986);
        check("carry_pre", m_disp, 32'h00599);
        clk_n(1);
        check("carry_pre2", m_disp, 32'h00599);
        clk_n(1);
        check("carry_1min", m_disp, 32'h01000);
        check("carry_min_o", {24'h0, m_min}, 32'h01);

        // laps
        rst = 1'b1; clk_n(1); rst = 1'b0;
        check("rst2_disp", m_disp, 32'h0);
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        clk_n(20);
        check("lap1_time", m_disp, 32'h00010);
        m_lap = 1'b1; clk_n(1); m_lap = 1'b0;
        check("lap1_count", {30'h0, m_count}, 32'h1);
        clk_n(29);
        check("lap2_time", m_disp, 32'h00025);
        m_lap = 1'b1; clk_n(1); m_lap = 1'b0;
        check("lap2_count", {30'h0, m_count}, 32'h2);
        check("lap_full", {31'h0, m_full}, 32'h1);
        m_lap = 1'b1; clk_n(1); m_lap = 1'b0;
        check("lap3_ignored", {30'h0, m_count}, 32'h2);
        clk_n(28);
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        check("lap_stop", m_disp, 32'h00040);
        m_recall = 1'b1; clk_n(1); m_recall = 1'b0;
        check("recall1_sel", {30'h0, m_sel}, 32'h1);
        check("recall1_disp", m_disp, 32'h00010);
        m_recall = 1'b1; clk_n(1); m_recall = 1'b0;
        check("recall2_sel", {30'h0, m_sel}, 32'h2);
        check("recall2_disp", m_disp, 32'h00025);
        m_recall = 1'b1; clk_n(1); m_recall = 1'b0;
        check("recall3_sel", {30'h0, m_sel}, 32'h0);
        check("recall3_disp", m_disp, 32'h00040);
        m_recall = 1'b1; clk_n(1); m_recall = 1'b0;
        m_toggle = 1'b1; m_recall = 1'b1; clk_n(1); m_toggle = 1'b0; m_recall = 1'b0;
        check("tog_recall_sel", {30'h0, m_sel}, 32'h0);
        check("tog_recall_disp", m_disp, 32'h00040);
        clk_n(1);
        check("tog_recall_run", m_disp, 32'h00041);

        // toggle and lap in the same cycle
        rst = 1'b1; clk_n(1); rst = 1'b0;
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        clk_n(20);
        m_lap = 1'b1; clk_n(1); m_lap = 1'b0;
        clk_n(1);
        m_toggle = 1'b1; m_lap = 1'b1; clk_n(1); m_toggle = 1'b0; m_lap = 1'b0;
        check("sim_stop_disp", m_disp, 32'h00011);
        check("sim_count", {30'h0, m_count}, 32'h2);
        clk_n(3);
        check("sim_stopped", m_disp, 32'h00011);
        m_recall = 1'b1; clk_n(1);
        check("sim_entry1", m_disp, 32'h00010);
        clk_n(1); m_recall = 1'b0;
        check("sim_entry2", m_disp, 32'h00011);
        m_recall = 1'b1; clk_n(1); m_recall = 1'b0;

        // reset mid-run
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        clk_n(51);
        check("mid_3_7", m_disp, 32'h00037);
        rst = 1'b1; clk_n(1); rst = 1'b0;
        check("mid_rst_disp", m_disp, 32'h0);
        check("mid_rst_count", {30'h0, m_count}, 32'h0);
        check("mid_rst_sel", {30'h0, m_sel}, 32'h0);
        check("mid_rst_flags", {30'h0, m_full, m_ovf}, 32'h0);
        m_toggle = 1'b1; clk_n(1); m_toggle = 1'b0;
        check("restart_zero", m_disp, 32'h0);
        clk_n(2);
        check("restart_tick", m_disp, 32'h00001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
